bgpu_ddr3_user_port: RTL and testbench
======================================

BGPU_DDR3_USER_PORT -- requirements
Module: bgpu_ddr3_user_port

Interface
REQ-001 Parameter AddrWidth, default 28: width of the DDR3 controller command address.
REQ-002 Parameter DataWidth, default 256: controller user data width, one BL8 beat.
REQ-003 Parameter TimeoutCycles, default 1024: read-wait limit, used only with the configuration macro.
REQ-004 Ports: clk_i in 1, the controller user clock; rst_i in 1, reset that is synchronous and active-high.
REQ-005 Request ports: req_valid_i in 1; req_ready_o out 1; req_we_i in 1; req_addr_i in AddrWidth-3, beat index; req_wdata_i in DataWidth; req_strb_i in DataWidth/8, byte enable.
REQ-006 Response ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_rdata_o out DataWidth; rsp_err_o out 1; rsp_we_o out 1, echoes the request type.
REQ-007 Controller ports: init_calib_complete_i in 1; cmd_ready_i in 1; cmd_en_o out 1; cmd_o out 3; addr_o out AddrWidth.
REQ-008 Controller data ports: wr_data_rdy_i in 1; wr_data_en_o out 1; wr_data_o out DataWidth; wr_data_end_o out 1; wr_data_mask_o out DataWidth/8; rd_data_valid_i in 1; rd_data_end_i in 1; rd_data_i in DataWidth.
REQ-009 Status output: busy_o out 1, high in every state except IDLE.

Function
REQ-010 The FSM SHALL have the states CALIB, IDLE, WRITE, READ_CMD, READ_WAIT and RESP.
REQ-011 CALIB: req_ready_o=0; go to IDLE in the cycle after init_calib_complete_i is sampled high.
REQ-012 IDLE: req_ready_o=1; on a valid&ready handshake, capture we, addr, wdata and strb, then go to WRITE if we=1 and READ_CMD otherwise.
REQ-013 addr_o SHALL equal {captured addr, 3'b000}; cmd_o SHALL be 3'b000 for a write and 3'b001 for a read.
REQ-014 WRITE: cmd_en_o stays high until the cycle with cmd_en_o&cmd_ready_i; wr_data_en_o and wr_data_end_o stay high until wr_data_en_o&wr_data_rdy_i; the command and data handshakes are tracked independently by the flags cmd_done and data_done.
REQ-015 In WRITE, both handshakes may complete in the same cycle or in either order; each strobe SHALL drop in the cycle after its own handshake.
REQ-016 wr_data_mask_o SHALL equal ~captured strb (1 = byte masked); wr_data_o SHALL equal the captured wdata.
REQ-017 WRITE goes to RESP once both flags are set, with rsp_err_o=0 and rsp_rdata_o='0.
REQ-018 READ_CMD: cmd_en_o stays high until cmd_ready_i, then the FSM goes to READ_WAIT.
REQ-019 READ_WAIT: the first cycle with rd_data_valid_i captures rd_data_i and goes to RESP; rd_data_end_i is ignored (single beat).
REQ-020 RESP: rsp_valid_o=1 and all outputs stay stable until rsp_ready_i; the FSM then goes to IDLE. A new request SHALL NOT be accepted in the same cycle.
REQ-021 rd_data_valid_i outside READ_WAIT SHALL be ignored.
REQ-022 At most one transaction SHALL be outstanding; a request-to-request turnaround is at least one IDLE cycle.
REQ-023 If init_calib_complete_i falls in any state, the FSM returns to CALIB: the transaction in flight is dropped, strobes go low and no response is issued.

Reset
REQ-024 While rst_i is high at a clk_i edge, the FSM goes to CALIB and flags and counters are cleared.
REQ-025 Reset values: all valid, enable and end outputs 0; req_ready_o=0; busy_o=1; data, address and mask registers '0.
REQ-026 Reset mid-transaction aborts it with no response.

Configuration
REQ-027 With BGPU_DDR3_USER_PORT_TIMEOUT_EN defined, a counter increments each READ_WAIT cycle. When it reaches TimeoutCycles-1 with no rd_data_valid_i, the FSM goes to RESP with rsp_err_o=1 and rsp_rdata_o='0.
REQ-028 Without BGPU_DDR3_USER_PORT_TIMEOUT_EN, no counter is synthesised, READ_WAIT waits indefinitely and rsp_err_o is tied 0.

Structure
REQ-029 Package bgpu_ddr3_pkg SHALL hold the command encodings (DDR3_CMD_WRITE=3'b000, DDR3_CMD_READ=3'b001) and the FSM state enum.
REQ-030 The design is a single module with no sub-modules.

Verification
REQ-031 Calib gating: hold init_calib_complete_i=0 for 50 cycles with req_valid_i=1 -> req_ready_o=0 and cmd_en_o=0 throughout; raise it -> ready in IDLE one cycle later.
REQ-032 Write with split handshakes: addr 0x1234, strb 0x0000_00FF, cmd_ready_i delayed 3 cycles, wr_data_rdy_i immediate -> addr_o=0x91A0, mask=0xFFFF_FF00, data strobe drops first, then one write response with err=0.
REQ-033 Read: addr 0x10, rd_data_valid_i 7 cycles after command acceptance with data 0xA5 pattern -> rsp_rdata_o=0xA5 pattern, rsp_we_o=0.
REQ-034 Response backpressure: rsp_ready_i held low 10 cycles -> rsp outputs stable and req_ready_o=0 until the response handshake.
REQ-035 Timeout (macro on, TimeoutCycles=16): no rd_data_valid_i -> error response after 16 READ_WAIT cycles; with the macro off, no response.
REQ-036 Abort: assert rst_i during WRITE, and separately drop calib during READ_WAIT -> strobes low the next cycle, FSM in CALIB, no response.

Source files
------------

// File: rtl/bgpu_ddr3_pkg.sv
// Shared encodings for the DDR3 user port: controller command codes and FSM states.
package bgpu_ddr3_pkg;

  localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR3_CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WRITE,
    ST_READ_CMD,
    ST_READ_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/bgpu_ddr3_user_port.sv
// Single-outstanding request/response bridge onto a DDR3 controller user interface (one BL8 beat).
// Optional read-wait timeout with error response: define BGPU_DDR3_USER_PORT_TIMEOUT_EN.
module bgpu_ddr3_user_port
  import bgpu_ddr3_pkg::*;
#(
  parameter int AddrWidth     = 28,
  parameter int DataWidth     = 256,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AddrWidth-4:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   rsp_we_o,
  input  logic                   init_calib_complete_i,
  input  logic                   cmd_ready_i,
  output logic                   cmd_en_o,
  output logic [2:0]             cmd_o,
  output logic [AddrWidth-1:0]   addr_o,
  input  logic                   wr_data_rdy_i,
  output logic                   wr_data_en_o,
  output logic [DataWidth-1:0]   wr_data_o,
  output logic                   wr_data_end_o,
  output logic [DataWidth/8-1:0] wr_data_mask_o,
  input  logic                   rd_data_valid_i,
  input  logic                   rd_data_end_i,
  input  logic [DataWidth-1:0]   rd_data_i,
  output logic                   busy_o
);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [AddrWidth-4:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] mask_q, mask_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   cmd_done_q, cmd_done_d;
  logic                   data_done_q, data_done_d;

  // Single-beat reads: the burst-end marker carries no information.
  logic unused_rd_end;
  assign unused_rd_end = rd_data_end_i;

`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign rsp_err_o = err_q;
`else
  localparam int unused_timeout = TimeoutCycles;
  assign rsp_err_o = 1'b0;
`endif

  assign req_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign cmd_en_o       = ((state_q == ST_WRITE) && !cmd_done_q) || (state_q == ST_READ_CMD);
  assign wr_data_en_o   = (state_q == ST_WRITE) && !data_done_q;
  assign wr_data_end_o  = wr_data_en_o;
  assign cmd_o          = we_q ? DDR3_CMD_WRITE : DDR3_CMD_READ;
  assign addr_o         = {addr_q, 3'b000};
  assign wr_data_o      = wdata_q;
  assign wr_data_mask_o = mask_q;
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_we_o       = we_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rdata_d     = rdata_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
    err_d = err_q;
    cnt_d = (state_q == ST_READ_WAIT) ? cnt_q + CntW'(1) : '0;
`endif
    case (state_q)
      ST_CALIB: if (init_calib_complete_i) state_d = ST_IDLE;
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          mask_d      = ~req_strb_i;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = req_we_i ? ST_WRITE : ST_READ_CMD;
        end
      end
      ST_WRITE: begin
        // Command and data channels complete independently, in any order.
        cmd_done_d  = cmd_done_q | cmd_ready_i;
        data_done_d = data_done_q | wr_data_rdy_i;
        if (cmd_done_d && data_done_d) begin
          rdata_d = '0;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
          err_d = 1'b0;
`endif
          state_d = ST_RESP;
        end
      end
      ST_READ_CMD: if (cmd_ready_i) state_d = ST_READ_WAIT;
      ST_READ_WAIT: begin
        if (rd_data_valid_i) begin
          rdata_d = rd_data_i;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
          err_d = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_CALIB;
    endcase
    // Losing calibration abandons whatever is in flight without a response.
    if (!init_calib_complete_i) state_d = ST_CALIB;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_CALIB;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
      err_q <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
      err_q <= err_d;
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bgpu_ddr3_user_port.sv
// Bench for bgpu_ddr3_user_port: vector table, random transactions against a transaction-level model, abort/timeout sequences.
module tb_bgpu_ddr3_user_port;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i, req_ready_o, req_we_i;
  logic [24:0]  req_addr_i;
  logic [255:0] req_wdata_i;
  logic [31:0]  req_strb_i;
  logic         rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_we_o;
  logic [255:0] rsp_rdata_o;
  logic         init_calib_complete_i, cmd_ready_i, cmd_en_o;
  logic [2:0]   cmd_o;
  logic [27:0]  addr_o;
  logic         wr_data_rdy_i, wr_data_en_o, wr_data_end_o;
  logic [255:0] wr_data_o;
  logic [31:0]  wr_data_mask_o;
  logic         rd_data_valid_i, rd_data_end_i;
  logic [255:0] rd_data_i;
  logic         busy_o;

  int n_pass = 0;
  int n_total = 0;

  bgpu_ddr3_user_port #(.AddrWidth(28), .DataWidth(256), .TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .init_calib_complete_i(init_calib_complete_i), .cmd_ready_i(cmd_ready_i),
    .cmd_en_o(cmd_en_o), .cmd_o(cmd_o), .addr_o(addr_o),
    .wr_data_rdy_i(wr_data_rdy_i), .wr_data_en_o(wr_data_en_o), .wr_data_o(wr_data_o),
    .wr_data_end_o(wr_data_end_o), .wr_data_mask_o(wr_data_mask_o),
    .rd_data_valid_i(rd_data_valid_i), .rd_data_end_i(rd_data_end_i), .rd_data_i(rd_data_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         we;
    logic [24:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  strb;
    int           cdly, ddly, rdly, rspdly;
    logic [255:0] rdat;
    logic [27:0]  exp_addr;
    logic [31:0]  exp_mask;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Response phase: hold off rsp_ready for rspdly cycles, then accept; a request
  // offered in the accepting cycle must not be taken.
  task automatic resp_phase(input logic [255:0] exp_rdata, input logic exp_err,
                            input logic exp_we, input int rspdly);
    for (int k = 0; k <= rspdly; k++) begin
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_rdata", rsp_rdata_o, exp_rdata);
      chk("rsp_err", rsp_err_o, exp_err);
      chk("rsp_we", rsp_we_o, exp_we);
      chk("rsp_req_ready", req_ready_o, 0);
      rsp_ready_i = (k == rspdly);
      req_valid_i = (k == rspdly);
      req_we_i    = 1'b1;
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
    chk("post_rsp_valid", rsp_valid_o, 0);
    chk("post_rsp_idle", req_ready_o, 1);
    req_valid_i = 1'b0;
  endtask

  // Model: addr_o = beat*8, mask = ~strb, strobes held until their own
  // handshake, response once both done; reads return the beat that arrives.
  task automatic run_txn(input vec_t v);
    bit cseen = 0, dseen = 0;
    chk("idle_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr;
    req_wdata_i = v.wdata; req_strb_i = v.strb;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (v.we) begin
      for (int c = 0; c < 200; c++) begin
        chk("wr_rsp_valid", rsp_valid_o, cseen && dseen);
        if (cseen && dseen) break;
        chk("wr_cmd_en", cmd_en_o, !cseen);
        chk("wr_data_en", wr_data_en_o, !dseen);
        chk("wr_data_end", wr_data_end_o, !dseen);
        if (c == 0) begin
          chk("wr_addr", addr_o, v.exp_addr);
          chk("wr_cmd", cmd_o, 3'b000);
          chk("wr_mask", wr_data_mask_o, v.exp_mask);
          chk("wr_data", wr_data_o, v.wdata);
        end
        cmd_ready_i   = (c >= v.cdly);
        wr_data_rdy_i = (c >= v.ddly);
        if (c >= v.cdly) cseen = 1;
        if (c >= v.ddly) dseen = 1;
        @(negedge clk_i);
      end
      cmd_ready_i = 1'b0; wr_data_rdy_i = 1'b0;
    end else begin
      for (int c = 0; c <= v.cdly; c++) begin
        chk("rd_cmd_en", cmd_en_o, 1);
        chk("rd_cmd_rsp", rsp_valid_o, 0);
        if (c == 0) begin
          chk("rd_addr", addr_o, v.exp_addr);
          chk("rd_cmd", cmd_o, 3'b001);
        end
        cmd_ready_i = (c == v.cdly);
        rd_data_valid_i = 1'b1;          // stray beat outside READ_WAIT
        rd_data_i = ~v.rdat;
        @(negedge clk_i);
      end
      cmd_ready_i = 1'b0;
      for (int j = 0; j <= v.rdly; j++) begin
        chk("rd_wait_cmd_en", cmd_en_o, 0);
        chk("rd_wait_rsp", rsp_valid_o, 0);
        rd_data_valid_i = (j == v.rdly);
        rd_data_i = v.rdat;
        @(negedge clk_i);
      end
      rd_data_valid_i = 1'b0;
    end
    resp_phase(v.exp_rdata, 1'b0, v.we, v.rspdly);
  endtask

  initial begin
    logic [255:0] pat_a5, pat_w, pat_r;
    vec_t rv;
    int seen;
    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'hDEADBEEF}};
    pat_r  = {8{32'h0123_4567}};
    //              we  addr        wdata   strb          cd dd rd rsp rdat    exp_addr      exp_mask      exp_rdata
    vecs[0] = '{1'b1, 25'h1234,    pat_w,  32'h0000_00FF, 3, 0, 0, 0, '0,     28'h91A0,     32'hFFFF_FF00, '0};
    vecs[1] = '{1'b0, 25'h10,      '0,     32'h0,         0, 0, 7, 0, pat_a5, 28'h80,       32'hFFFF_FFFF, pat_a5};
    vecs[2] = '{1'b1, 25'h0,       ~pat_w, 32'hFFFF_FFFF, 0, 0, 0, 1, '0,     28'h0,        32'h0,         '0};
    vecs[3] = '{1'b1, 25'h1FFFFFF, pat_r,  32'h0,         0, 4, 0, 0, '0,     28'hFFFFFF8,  32'hFFFF_FFFF, '0};
    vecs[4] = '{1'b0, 25'h1FFFFFF, '0,     32'hF0F0_0F0F, 2, 0, 0, 10, pat_r, 28'hFFFFFF8,  32'h0F0F_F0F0, pat_r};
    vecs[5] = '{1'b1, 25'h0ABCDE,  pat_a5, 32'h8000_0001, 1, 1, 0, 10, '0,    28'h055E6F0,  32'h7FFF_FFFE, '0};

    rst_i = 1'b1; init_calib_complete_i = 1'b0;
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_wdata_i = '0; req_strb_i = '0;
    rsp_ready_i = 0; cmd_ready_i = 0; wr_data_rdy_i = 0;
    rd_data_valid_i = 0; rd_data_end_i = 0; rd_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_cmd_en", cmd_en_o, 0);
    chk("rst_wr_en", {wr_data_en_o, wr_data_end_o}, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_mask", wr_data_mask_o, 0);
    chk("rst_wdata", wr_data_o, 0);

    // Calibration gating with a request pending.
    rst_i = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      chk("calib_ready", req_ready_o, 0);
      chk("calib_cmd_en", cmd_en_o, 0);
    end
    req_valid_i = 1'b0; init_calib_complete_i = 1'b1;
    @(negedge clk_i);
    chk("calib_up_ready", req_ready_o, 1);
    chk("calib_up_busy", busy_o, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.addr  = 25'($urandom);
      for (int w = 0; w < 8; w++) begin
        rv.wdata[w*32 +: 32] = $urandom;
        rv.rdat[w*32 +: 32]  = $urandom;
      end
      rv.strb   = $urandom;
      rv.cdly   = $urandom_range(0, 4);
      rv.ddly   = $urandom_range(0, 4);
      rv.rdly   = $urandom_range(0, 5);
      rv.rspdly = $urandom_range(0, 3);
      rv.exp_addr  = 28'(rv.addr) * 28'd8;
      rv.exp_mask  = ~rv.strb;
      rv.exp_rdata = rv.we ? 256'd0 : rv.rdat;
      run_txn(rv);
    end

    // Reset in the middle of a write.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 25'h55;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("abort_wr_cmd_en", cmd_en_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_rst_cmd_en", cmd_en_o, 0);
    chk("abort_rst_wr_en", wr_data_en_o, 0);
    chk("abort_rst_rsp", rsp_valid_o, 0);
    chk("abort_rst_busy", busy_o, 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_rst_recover", req_ready_o, 1);
    chk("abort_rst_norsp", rsp_valid_o, 0);

    // Calibration lost while waiting for read data.
    req_valid_i = 1'b1; req_we_i = 1'b0; cmd_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    cmd_ready_i = 1'b0;
    @(negedge clk_i);
    init_calib_complete_i = 1'b0; rd_data_valid_i = 1'b1; rd_data_i = pat_a5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("abort_cal_cmd_en", cmd_en_o, 0);
      chk("abort_cal_rsp", rsp_valid_o, 0);
      chk("abort_cal_ready", req_ready_o, 0);
      chk("abort_cal_busy", busy_o, 1);
    end
    rd_data_valid_i = 1'b0; init_calib_complete_i = 1'b1;
    @(negedge clk_i);
    chk("abort_cal_recover", req_ready_o, 1);
    chk("abort_cal_norsp", rsp_valid_o, 0);

    // Read with no data ever returned.
    req_valid_i = 1'b1; req_we_i = 1'b0; cmd_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    cmd_ready_i = 1'b0;
`ifdef BGPU_DDR3_USER_PORT_TIMEOUT_EN
    for (int j = 0; j < 16; j++) begin
      chk("tmo_wait_rsp", rsp_valid_o, 0);
      @(negedge clk_i);
    end
    resp_phase(256'd0, 1'b1, 1'b0, 2);
`else
    seen = 0;
    for (int j = 0; j < 100; j++) begin
      if (rsp_valid_o) seen++;
      @(negedge clk_i);
    end
    chk("no_tmo_rsp", seen, 0);
    chk("no_tmo_busy", busy_o, 1);
    init_calib_complete_i = 1'b0;
    @(negedge clk_i);
    init_calib_complete_i = 1'b1;
    @(negedge clk_i);
    chk("no_tmo_recover", req_ready_o, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
